// File: rtl/aes_pkg.sv
// Shared AES constants: key-size encodings, Nk/Nr, Rcon table and widths.
package aes_pkg;
   localparam int WORD_W = 32;
   localparam int RKEY_W = 128;
   localparam int KEY_W  = 256;

   typedef enum logic [1:0] {
      KS_128 = 2'd0,
      KS_192 = 2'd1,
      KS_256 = 2'd2,
      KS_BAD = 2'd3
   } key_size_e;

   typedef enum logic {
      ST_IDLE,
      ST_EXPAND
   } state_e;

   localparam logic [3:0] NK_128 = 4'd4;
   localparam logic [3:0] NK_192 = 4'd6;
   localparam logic [3:0] NK_256 = 4'd8;
   localparam logic [3:0] NR_128 = 4'd10;
   localparam logic [3:0] NR_192 = 4'd12;
   localparam logic [3:0] NR_256 = 4'd14;

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      logic [7:0] r;
      case (idx)
         4'd0:    r = 8'h01;
         4'd1:    r = 8'h02;
         4'd2:    r = 8'h04;
         4'd3:    r = 8'h08;
         4'd4:    r = 8'h10;
         4'd5:    r = 8'h20;
         4'd6:    r = 8'h40;
         4'd7:    r = 8'h80;
         4'd8:    r = 8'h1b;
         4'd9:    r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] nk_of(input logic [1:0] ks);
      logic [3:0] n;
      case (ks)
         KS_192:  n = NK_192;
         KS_256:  n = NK_256;
         default: n = NK_128;
      endcase
      return n;
   endfunction

   function automatic logic [3:0] nr_of(input logic [1:0] ks);
      logic [3:0] n;
      case (ks)
         KS_192:  n = NR_192;
         KS_256:  n = NR_256;
         default: n = NR_128;
      endcase
      return n;
   endfunction
endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
// Purely combinational, no handshake.
module aes_sub_word
   import aes_pkg::*;
(
   input  logic [WORD_W-1:0] data,
   output logic [WORD_W-1:0] result
);
   for (genvar b = 0; b < 4; b++) begin : g_byte
      s_box u_s_box (
         .data   (data[8*b +: 8]),
         .result (result[8*b +: 8])
      );
   end
endmodule

// File: rtl/s_box.sv
// AES forward S-box: GF(2^8) inverse (x^254) followed by the affine map.
// Purely combinational, no handshake.
module s_box (
   input  logic [7:0] data,
   output logic [7:0] result
);
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] aa;
      acc = 8'h00;
      aa  = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) acc = acc ^ aa;
         aa = xtime(aa);
      end
      return acc;
   endfunction

   // x^254 = x^(2+4+...+128); zero maps to zero without a special case
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] r;
      sq = a;
      r  = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] affine(input logic [7:0] a);
      return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
               ^ {a[3:0], a[7:4]} ^ 8'h63;
   endfunction

   assign result = affine(ginv(data));
endmodule

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key expansion, one schedule word per clock into a word store.
// Round keys are read with one cycle latency; start is ignored while busy (no queueing).
module aes_key_schedule_seq
   import aes_pkg::*;
#(
   parameter int MAX_ROUNDS = 14,
   parameter int RSEL_W     = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        keySize,
   input  logic [KEY_W-1:0]  cipherKey,
   output logic              busy,
   output logic              done,
   output logic              keysValid,
   output logic              keyError,
   output logic [3:0]        numRounds,
   input  logic [RSEL_W-1:0] roundSel,
   output logic [RKEY_W-1:0] roundKey
);
   localparam int NWORDS = 4 * (MAX_ROUNDS + 1);
   localparam int IDX_W  = $clog2(NWORDS);

   logic [WORD_W-1:0] wstore [NWORDS];

   state_e            state_q, state_d;
   logic              accept, key_err, step, finish;
   logic [3:0]        nk_q;
   logic [IDX_W-1:0]  last_q, i_q;
   logic [2:0]        p_q;
   logic [3:0]        rc_q;
   logic [WORD_W-1:0] prev_w, old_w, sub_in, sub_out, tmp_w, new_w;
   logic [IDX_W-1:0]  rd_base;
   logic              rd_ok;

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      key_err = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (keySize == KS_BAD) begin
                  key_err = 1'b1;
               end else begin
                  accept  = 1'b1;
                  state_d = ST_EXPAND;
               end
            end
         end
         ST_EXPAND: begin
            step = 1'b1;
            if (i_q == last_q) begin
               finish  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign prev_w = wstore[i_q - IDX_W'(1)];
   assign old_w  = wstore[i_q - IDX_W'(nk_q)];
   assign sub_in = (p_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

   aes_sub_word u_sub_word (
      .data   (sub_in),
      .result (sub_out)
   );

   always_comb begin
      tmp_w = prev_w;
      if (p_q == 3'd0)
         tmp_w = sub_out ^ {rcon(rc_q), 24'h000000};
      else if (nk_q == NK_256 && p_q == 3'd4)
         tmp_w = sub_out;
      new_w = old_w ^ tmp_w;
   end

   // Key words land in one edge; expansion words one per edge thereafter.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < 8; k++) begin
            if (k < int'(nk_of(keySize)))
               wstore[IDX_W'(k)] <= cipherKey[KEY_W-1-32*k -: 32];
         end
      end else if (step) begin
         wstore[i_q] <= new_w;
      end
   end

   assign rd_base = IDX_W'({roundSel, 2'b00});
   assign rd_ok   = (int'(roundSel) <= int'(numRounds)) && (int'(roundSel) <= MAX_ROUNDS);

   always_ff @(posedge clk) begin
      if (reset) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         keysValid <= 1'b0;
         keyError  <= 1'b0;
         numRounds <= 4'd0;
         roundKey  <= '0;
         nk_q      <= 4'd0;
         last_q    <= '0;
         i_q       <= '0;
         p_q       <= 3'd0;
         rc_q      <= 4'd0;
      end else begin
         done     <= finish;
         keyError <= key_err;
         if (accept) begin
            nk_q      <= nk_of(keySize);
            numRounds <= nr_of(keySize);
            last_q    <= IDX_W'({nr_of(keySize), 2'b11});
            i_q       <= IDX_W'(nk_of(keySize));
            p_q       <= 3'd0;
            rc_q      <= 4'd0;
            keysValid <= 1'b0;
            busy      <= 1'b1;
         end
         if (step) begin
            i_q <= i_q + IDX_W'(1);
            p_q <= ({1'b0, p_q} == nk_q - 4'd1) ? 3'd0 : p_q + 3'd1;
            if (p_q == 3'd0) rc_q <= rc_q + 4'd1;
            if (finish) begin
               busy      <= 1'b0;
               keysValid <= 1'b1;
            end
         end
         if (rd_ok)
            roundKey <= {wstore[rd_base], wstore[rd_base + IDX_W'(1)],
                         wstore[rd_base + IDX_W'(2)], wstore[rd_base + IDX_W'(3)]};
         else
            roundKey <= '0;
      end
   end
endmodule
